// File: rtl/keypad_matrix_emulator_if.sv
// keypad_matrix_emulator_if: key-code valid/ready handshake between a key source and the emulator.
interface keypad_matrix_emulator_if;
    logic [4:0] key_code;
    logic       key_valid;
    logic       key_ready;
    modport master (output key_code, key_valid, input key_ready);
    modport slave  (input key_code, key_valid, output key_ready);
endinterface

// File: rtl/keypad_matrix_emulator.sv
// keypad_matrix_emulator: plays one timed, bounced press/release of a 4x4 keypad key
// onto the row lines in answer to the scanner's column drive.
module keypad_matrix_emulator #(
    parameter int CNT_W         = 16,
    parameter int BOUNCE_CYCLES = 8,
    parameter int HOLD_CYCLES   = 1000,
    parameter int GAP_CYCLES    = 100
) (
    input  logic                     CLK,
    input  logic                     RST_n,
    keypad_matrix_emulator_if.slave  bus,
    output logic                     busy,
    output logic                     done,
    output logic                     key_invalid,
    input  logic [3:0]               keyCols,
    output logic [3:0]               keyRows
);
    typedef enum logic [2:0] {IDLE, BOUNCE_IN, PRESS, BOUNCE_OUT, GAP} state_t;
    localparam logic [CNT_W-1:0] B_LD = CNT_W'(BOUNCE_CYCLES > 0 ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] H_LD = CNT_W'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] G_LD = CNT_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [4:0]       code_q;
    logic             contact, contact_n, done_n, accept, mapped, in_mapped;
    logic [1:0]       col, row;
    // {mapped, col, row}; an unmapped code decodes to all zeros
    function automatic logic [4:0] decode(input logic [4:0] c);
        case (c)
            5'h01:   decode = 5'b1_11_11;
            5'h02:   decode = 5'b1_10_11;
            5'h03:   decode = 5'b1_01_11;
            5'h04:   decode = 5'b1_11_10;
            5'h05:   decode = 5'b1_10_10;
            5'h06:   decode = 5'b1_01_10;
            5'h07:   decode = 5'b1_11_01;
            5'h08:   decode = 5'b1_10_01;
            5'h09:   decode = 5'b1_01_01;
            5'h00:   decode = 5'b1_11_00;
            5'h1C:   decode = 5'b1_10_00;
            5'h1E:   decode = 5'b1_01_00;
            5'h18:   decode = 5'b1_00_00;
            default: decode = 5'b0_00_00;
        endcase
    endfunction
    assign accept          = bus.key_valid && state == IDLE;
    assign bus.key_ready   = state == IDLE;
    assign busy            = state != IDLE;
    assign in_mapped       = |decode(bus.key_code);
    assign {mapped, col, row} = decode(code_q);
    assign keyRows = (contact && mapped && keyCols[col]) ? 4'b0001 << row : 4'b0000;
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state       <= IDLE;
            cnt         <= '0;
            code_q      <= 5'b11111;
            contact     <= 1'b0;
            done        <= 1'b0;
            key_invalid <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            code_q      <= accept ? bus.key_code : code_q;
            contact     <= contact_n;
            done        <= done_n;
            key_invalid <= accept && !in_mapped;
        end
    end
    // Bounce phases toggle contact every cycle; zero-length phases are skipped at entry
    always_comb begin
        state_n   = state;
        cnt_n     = cnt == '0 ? cnt : cnt - CNT_W'(1);
        contact_n = (state == BOUNCE_IN || state == BOUNCE_OUT) ? ~contact : contact;
        done_n    = 1'b0;
        case (state)
            IDLE: if (accept) begin
                state_n   = BOUNCE_CYCLES > 0 ? BOUNCE_IN : PRESS;
                cnt_n     = BOUNCE_CYCLES > 0 ? B_LD : H_LD;
                contact_n = 1'b1;
            end
            BOUNCE_IN: if (cnt == '0) begin
                state_n   = PRESS;
                cnt_n     = H_LD;
                contact_n = 1'b1;
            end
            PRESS: if (cnt == '0) begin
                state_n   = BOUNCE_CYCLES > 0 ? BOUNCE_OUT : GAP_CYCLES > 0 ? GAP : IDLE;
                cnt_n     = BOUNCE_CYCLES > 0 ? B_LD : G_LD;
                contact_n = 1'b0;
                done_n    = BOUNCE_CYCLES == 0 && GAP_CYCLES == 0;
            end
            BOUNCE_OUT: if (cnt == '0) begin
                state_n   = GAP_CYCLES > 0 ? GAP : IDLE;
                cnt_n     = G_LD;
                contact_n = 1'b0;
                done_n    = GAP_CYCLES == 0;
            end
            GAP: if (cnt == '0) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// tb_keypad_matrix_emulator: scoreboard bench for the keypad emulator, with a second
// instance built without bounce or gap phases.
module tb_keypad_matrix_emulator;
    logic       CLK = 1'b0;
    logic       RST_n = 1'b0;
    logic [3:0] cols = 4'b0, cols2 = 4'b0;
    logic [3:0] rows, rows2;
    logic       busy, done, key_invalid, busy2, done2, inv2;
    int         total = 0;
    int         bad = 0;
    logic [3:0] exp_q[$];

    keypad_matrix_emulator_if kif();
    keypad_matrix_emulator_if kif2();

    keypad_matrix_emulator #(.CNT_W(16), .BOUNCE_CYCLES(4), .HOLD_CYCLES(4), .GAP_CYCLES(2)) dut (
        .CLK(CLK), .RST_n(RST_n), .bus(kif), .busy(busy), .done(done),
        .key_invalid(key_invalid), .keyCols(cols), .keyRows(rows));

    keypad_matrix_emulator #(.CNT_W(16), .BOUNCE_CYCLES(0), .HOLD_CYCLES(4), .GAP_CYCLES(0)) dut2 (
        .CLK(CLK), .RST_n(RST_n), .bus(kif2), .busy(busy2), .done(done2),
        .key_invalid(inv2), .keyCols(cols2), .keyRows(rows2));

    always #5 CLK = ~CLK;

    function automatic logic [4:0] key_map(input logic [4:0] c);
        case (c)
            5'h01: return {1'b1, 2'd3, 2'd3};
            5'h02: return {1'b1, 2'd2, 2'd3};
            5'h03: return {1'b1, 2'd1, 2'd3};
            5'h04: return {1'b1, 2'd3, 2'd2};
            5'h05: return {1'b1, 2'd2, 2'd2};
            5'h06: return {1'b1, 2'd1, 2'd2};
            5'h07: return {1'b1, 2'd3, 2'd1};
            5'h08: return {1'b1, 2'd2, 2'd1};
            5'h09: return {1'b1, 2'd1, 2'd1};
            5'h00: return {1'b1, 2'd3, 2'd0};
            5'h1C: return {1'b1, 2'd2, 2'd0};
            5'h1E: return {1'b1, 2'd1, 2'd0};
            5'h18: return {1'b1, 2'd0, 2'd0};
            default: return 5'b0;
        endcase
    endfunction

    // Expected rows for cycle i of a 4/4/4/2 press under column drive c
    function automatic logic [3:0] model_rows(input logic [4:0] code, input int i, input logic [3:0] c);
        logic [4:0] k;
        logic con;
        k = key_map(code);
        con = i < 4 ? (i % 2 == 0) : i < 8 ? 1'b1 : i < 12 ? (i % 2 == 1) : 1'b0;
        return (con && k[4] && c[k[3:2]]) ? 4'b0001 << k[1:0] : 4'b0000;
    endfunction

    task automatic accept(input logic [4:0] code);
        @(negedge CLK);
        kif.key_code = code;
        kif.key_valid = 1'b1;
        @(negedge CLK);
        kif.key_valid = 1'b0;
    endtask

    task automatic test_reset();
        RST_n = 1'b0;
        kif.key_valid = 1'b0;
        kif.key_code = 5'h00;
        kif2.key_valid = 1'b0;
        kif2.key_code = 5'h00;
        cols = 4'b1111;
        cols2 = 4'b1111;
        repeat (3) @(negedge CLK);
        #1;
        total++;
        if (rows !== 4'b0 || rows2 !== 4'b0) begin
            bad++;
            $display("FAIL reset_rows got %b/%b want 0000/0000", rows, rows2);
        end
        total++;
        if (kif.key_ready !== 1'b1 || busy !== 1'b0 || kif2.key_ready !== 1'b1 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready_busy got ready=%b busy=%b ready2=%b busy2=%b want 1 0 1 0",
                     kif.key_ready, busy, kif2.key_ready, busy2);
        end
        total++;
        if (done !== 1'b0 || key_invalid !== 1'b0 || done2 !== 1'b0 || inv2 !== 1'b0) begin
            bad++;
            $display("FAIL reset_pulses got done=%b inv=%b done2=%b inv2=%b want all 0",
                     done, key_invalid, done2, inv2);
        end
        RST_n = 1'b1;
    endtask

    task automatic test_patterns();
        logic [4:0] codes[4] = '{5'h05, 5'h05, 5'h18, 5'h1F};
        bit         rot[4]   = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] hold[4]  = '{4'b0100, 4'b0100, 4'b0001, 4'b1111};
        logic [4:0] k;
        logic [3:0] c, e;
        for (int t = 0; t < 4; t++) begin
            k = key_map(codes[t]);
            for (int i = 0; i < 14; i++) begin
                c = rot[t] ? 4'b1000 >> (i % 4) : hold[t];
                exp_q.push_back(model_rows(codes[t], i, c));
            end
            accept(codes[t]);
            for (int i = 0; i < 14; i++) begin
                cols = rot[t] ? 4'b1000 >> (i % 4) : hold[t];
                #1;
                e = exp_q.pop_front();
                total++;
                if (rows !== e) begin
                    bad++;
                    $display("FAIL pat%0d_rows cyc%0d got %b want %b", t, i, rows, e);
                end
                total++;
                if (key_invalid !== (i == 0 && !k[4])) begin
                    bad++;
                    $display("FAIL pat%0d_invalid cyc%0d got %b want %b", t, i, key_invalid, i == 0 && !k[4]);
                end
                total++;
                if (done !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL pat%0d_busy cyc%0d got done=%b busy=%b want 0 1", t, i, done, busy);
                end
                @(negedge CLK);
            end
            #1;
            total++;
            if (done !== 1'b1 || kif.key_ready !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL pat%0d_done got done=%b ready=%b busy=%b want 1 1 0", t, done, kif.key_ready, busy);
            end
            @(negedge CLK);
            #1;
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL pat%0d_done_pulse got %b want 0", t, done);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e;
        cols = 4'b1010;
        for (int i = 0; i < 14; i++) exp_q.push_back(model_rows(5'h01, i, 4'b1010));
        for (int i = 0; i < 14; i++) exp_q.push_back(model_rows(5'h09, i, 4'b1010));
        @(negedge CLK);
        kif.key_code = 5'h01;
        kif.key_valid = 1'b1;
        @(negedge CLK);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 14; i++) begin
                #1;
                if (i == 0) begin
                    kif.key_code = 5'h09;
                    if (p == 1) kif.key_valid = 1'b0;
                end
                e = exp_q.pop_front();
                total++;
                if (rows !== e || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b%0d_rows cyc%0d got rows=%b busy=%b want %b 1", p, i, rows, busy, e);
                end
                @(negedge CLK);
            end
            #1;
            total++;
            if (done !== 1'b1 || kif.key_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b%0d_done got done=%b ready=%b want 1 1", p, done, kif.key_ready);
            end
            @(negedge CLK);
        end
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        cols = 4'b0100;
        accept(5'h05);
        repeat (5) @(negedge CLK);
        #1;
        total++;
        if (rows !== 4'b0100) begin
            bad++;
            $display("FAIL mid_press_rows got %b want 0100", rows);
        end
        RST_n = 1'b0;
        @(negedge CLK);
        RST_n = 1'b1;
        #1;
        total++;
        if (rows !== 4'b0 || kif.key_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got rows=%b ready=%b busy=%b done=%b want 0000 1 0 0",
                     rows, kif.key_ready, busy, done);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            #1;
            total++;
            if (done !== 1'b0 || rows !== 4'b0) begin
                bad++;
                $display("FAIL mid_no_done cyc%0d got done=%b rows=%b want 0 0000", i, done, rows);
            end
        end
        accept(5'h05);
        #1;
        total++;
        if (rows !== 4'b0100 || busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_reaccept got rows=%b busy=%b want 0100 1", rows, busy);
        end
        repeat (14) @(negedge CLK);
        #1;
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL mid_reaccept_done got %b want 1", done);
        end
    endtask

    task automatic test_no_bounce();
        cols2 = 4'b0100;
        @(negedge CLK);
        kif2.key_code = 5'h05;
        kif2.key_valid = 1'b1;
        @(negedge CLK);
        kif2.key_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (rows2 !== 4'b0100 || done2 !== 1'b0) begin
                bad++;
                $display("FAIL nob_rows cyc%0d got rows=%b done=%b want 0100 0", i, rows2, done2);
            end
            @(negedge CLK);
        end
        #1;
        total++;
        if (done2 !== 1'b1 || kif2.key_ready !== 1'b1 || rows2 !== 4'b0 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL nob_done got done=%b ready=%b rows=%b busy=%b want 1 1 0000 0",
                     done2, kif2.key_ready, rows2, busy2);
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_back_to_back();
        test_reset_mid();
        test_no_bounce();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
